// File: rtl/ks_control_unit_if.sv
// Opcode type shared by the K&S decoder and controller, plus the controller <-> datapath/RAM bundle.
// The controller drives every strobe and reads back the decoded opcode and the registered flags.
package ks_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_ADD, I_SUB, I_AND, I_OR, I_MOVE, I_LOAD, I_STORE,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_HALT
    } decoded_instruction_type;
endpackage

interface ks_control_unit_if;
    ks_pkg::decoded_instruction_type decoded_instruction;
    logic       zero_op;
    logic       neg_op;
    logic       unsigned_overflow;
    logic       signed_overflow;
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable
    );
endinterface

// File: rtl/ks_control_unit.sv
// Multi-cycle sequencer for the K&S 16-bit datapath: fetch, decode, execute with MEM_WAIT-cycle RAM access.
// Keeps shadow copies of zero/negative because the datapath only presents them for one cycle after an ALU op.
module ks_control_unit #(
    parameter int MEM_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ks_control_unit_if.master    bus,
    output logic                 halted,
    output logic [15:0]          retired
);
    import ks_pkg::*;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC_ALU, EXEC_MOVE, EXEC_LOAD, EXEC_STORE, EXEC_BR, HALT
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(MEM_WAIT - 1);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       last;
    logic       z_q, n_q;
    logic       capture_q;
    logic       taken;
    logic       retire;
    logic       unused_ovf;

    // Overflow flags are only observed for debug in this revision.
    assign unused_ovf = bus.unsigned_overflow ^ bus.signed_overflow;
    assign last       = (cnt == LAST_CNT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            cnt       <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            capture_q <= 1'b0;
            retired   <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            capture_q <= (state == EXEC_ALU);
            if (capture_q) begin
                z_q <= bus.zero_op;
                n_q <= bus.neg_op;
            end
            if (retire) retired <= retired + 16'd1;
        end
    end

    // NOTE: every output and next-state value is defaulted before the case so no latch is inferred.
    always_comb begin
        state_next           = state;
        cnt_next             = '0;
        taken                = 1'b0;
        retire               = 1'b0;
        halted               = 1'b0;
        bus.branch           = 1'b0;
        bus.pc_enable        = 1'b0;
        bus.ir_enable        = 1'b0;
        bus.addr_sel         = 1'b1;
        bus.c_sel            = 1'b0;
        bus.operation        = 2'b00;
        bus.write_reg_enable = 1'b0;
        bus.flags_reg_enable = 1'b0;
        bus.ram_write_enable = 1'b0;

        case (state)
            FETCH: begin
                if (last) begin
                    bus.ir_enable = 1'b1;
                    state_next    = DECODE;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            DECODE: begin
                bus.pc_enable = 1'b1;
                case (bus.decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR:                   state_next = EXEC_ALU;
                    I_MOVE:                                      state_next = EXEC_MOVE;
                    I_LOAD:                                      state_next = EXEC_LOAD;
                    I_STORE:                                     state_next = EXEC_STORE;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: state_next = EXEC_BR;
                    I_HALT:                                      state_next = HALT;
                    default:                                     state_next = FETCH;
                endcase
            end
            EXEC_ALU: begin
                bus.write_reg_enable = 1'b1;
                bus.flags_reg_enable = 1'b1;
                case (bus.decoded_instruction)
                    I_ADD:   bus.operation = 2'b01;
                    I_SUB:   bus.operation = 2'b10;
                    I_AND:   bus.operation = 2'b11;
                    default: bus.operation = 2'b00;
                endcase
                state_next = FETCH;
            end
            EXEC_MOVE: begin
                bus.write_reg_enable = 1'b1;
                state_next           = FETCH;
            end
            EXEC_LOAD: begin
                bus.addr_sel = 1'b0;
                bus.c_sel    = 1'b1;
                if (last) begin
                    bus.write_reg_enable = 1'b1;
                    state_next           = FETCH;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            EXEC_STORE: begin
                bus.addr_sel = 1'b0;
                if (last) begin
                    bus.ram_write_enable = 1'b1;
                    state_next           = FETCH;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            EXEC_BR: begin
                case (bus.decoded_instruction)
                    I_BRANCH: taken = 1'b1;
                    I_BZERO:  taken = z_q;
                    I_BNZERO: taken = !z_q;
                    I_BNEG:   taken = n_q;
                    I_BNNEG:  taken = !n_q;
                    default:  taken = 1'b0;
                endcase
                bus.branch    = taken;
                bus.pc_enable = taken;
                state_next    = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // HALT never leaves, so only completed instructions land here.
        retire = (state_next == FETCH) && (state != FETCH) && (state != HALT);
    end
endmodule

// File: tb/tb_ks_control_unit.sv
// Bench for ks_control_unit: one instance at MEM_WAIT=1 and one at MEM_WAIT=3, checked every cycle
// against a per-instruction schedule model, plus literal checks on CPI, retire count and reset.
module tb_ks_control_unit;
    import ks_pkg::*;

    typedef struct packed {
        logic       branch;
        logic       pc_enable;
        logic       ir_enable;
        logic       addr_sel;
        logic       c_sel;
        logic [1:0] operation;
        logic       write_reg_enable;
        logic       flags_reg_enable;
        logic       ram_write_enable;
        logic       halted;
    } ctrl_t;

    typedef struct {
        int          sel;
        ctrl_t       word;
        logic [15:0] ret;
        string       tag;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_w1, rst_w3;
    logic        halted_w1, halted_w3;
    logic [15:0] retired_w1, retired_w3;

    ks_control_unit_if if_w1();
    ks_control_unit_if if_w3();

    ks_control_unit #(.MEM_WAIT(1)) u_dut_w1 (
        .clk(clk), .rst(rst_w1), .bus(if_w1.master), .halted(halted_w1), .retired(retired_w1)
    );
    ks_control_unit #(.MEM_WAIT(3)) u_dut_w3 (
        .clk(clk), .rst(rst_w3), .bus(if_w3.master), .halted(halted_w3), .retired(retired_w3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: 0 -> MEM_WAIT=1, 1 -> MEM_WAIT=3.
    int          mw[2] = '{1, 3};
    logic [15:0] mret[2];
    logic        mz[2], mn[2];
    logic        pend[2], pz[2], pn[2];
    exp_t        exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic ctrl_t read_dut(input int sel);
        ctrl_t r;
        if (sel == 0)
            r = {if_w1.branch, if_w1.pc_enable, if_w1.ir_enable, if_w1.addr_sel, if_w1.c_sel,
                 if_w1.operation, if_w1.write_reg_enable, if_w1.flags_reg_enable,
                 if_w1.ram_write_enable, halted_w1};
        else
            r = {if_w3.branch, if_w3.pc_enable, if_w3.ir_enable, if_w3.addr_sel, if_w3.c_sel,
                 if_w3.operation, if_w3.write_reg_enable, if_w3.flags_reg_enable,
                 if_w3.ram_write_enable, halted_w3};
        return r;
    endfunction

    // Compare process: one expected entry per clock cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                check({e.tag, " ctrl"}, 32'(read_dut(e.sel)), 32'(e.word));
                check({e.tag, " retired"}, (e.sel == 0) ? 32'(retired_w1) : 32'(retired_w3), 32'(e.ret));
            end
        end
    end

    // Distance between ir_enable pulses on the W=3 instance equals the CPI of the earlier instruction.
    int cyc3 = 0, last_ir3 = 0, ir_gap3 = 0;
    always @(negedge clk) begin
        cyc3++;
        if (if_w3.ir_enable && !rst_w3) begin
            ir_gap3  = cyc3 - last_ir3;
            last_ir3 = cyc3;
        end
    end

    task automatic set_in(input int sel, input decoded_instruction_type ins, input logic z, input logic n);
        if (sel == 0) begin
            if_w1.decoded_instruction = ins;
            if_w1.zero_op = z;
            if_w1.neg_op  = n;
        end else begin
            if_w3.decoded_instruction = ins;
            if_w3.zero_op = z;
            if_w3.neg_op  = n;
        end
    endtask

    task automatic step(input int sel, input ctrl_t w, input string tag, input bit chk);
        exp_t e;
        e.sel = sel; e.word = w; e.ret = mret[sel]; e.tag = tag; e.chk = chk;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sel, input int cycles);
        ctrl_t w;
        rst_w1 = 1'b1;
        rst_w3 = 1'b1;
        set_in(sel, I_NOP, 1'b0, 1'b0);
        mret[sel] = '0; mz[sel] = 1'b0; mn[sel] = 1'b0; pend[sel] = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            w = '0;
            w.addr_sel  = 1'b1;
            w.ir_enable = (mw[sel] == 1);
            step(sel, w, $sformatf("w%0d reset%0d", mw[sel], i), i > 0);
        end
        if (sel == 0) rst_w1 = 1'b0;
        else          rst_w3 = 1'b0;
    endtask

    // Builds the full cycle schedule of one instruction from the ISA timing rules, then plays it.
    // rz/rn are the flags the datapath presents after this instruction if it is an ALU op.
    task automatic issue(input int sel, input decoded_instruction_type ins,
                         input logic rz, input logic rn, input int stop_at);
        ctrl_t seq[$];
        ctrl_t w;
        logic  cap, ez, en, tk;
        string nm;
        nm  = $sformatf("w%0d op%0d", mw[sel], int'(ins));
        cap = pend[sel];
        ez  = cap ? pz[sel] : mz[sel];
        en  = cap ? pn[sel] : mn[sel];
        for (int k = 0; k < mw[sel]; k++) begin
            w = '0; w.addr_sel = 1'b1; w.ir_enable = (k == mw[sel] - 1);
            seq.push_back(w);
        end
        w = '0; w.addr_sel = 1'b1; w.pc_enable = 1'b1;
        seq.push_back(w);
        case (ins)
            I_ADD, I_SUB, I_AND, I_OR: begin
                w = '0; w.addr_sel = 1'b1; w.write_reg_enable = 1'b1; w.flags_reg_enable = 1'b1;
                w.operation = (ins == I_ADD) ? 2'b01 : (ins == I_SUB) ? 2'b10 : (ins == I_AND) ? 2'b11 : 2'b00;
                seq.push_back(w);
            end
            I_MOVE: begin
                w = '0; w.addr_sel = 1'b1; w.write_reg_enable = 1'b1;
                seq.push_back(w);
            end
            I_LOAD: for (int k = 0; k < mw[sel]; k++) begin
                w = '0; w.c_sel = 1'b1; w.write_reg_enable = (k == mw[sel] - 1);
                seq.push_back(w);
            end
            I_STORE: for (int k = 0; k < mw[sel]; k++) begin
                w = '0; w.ram_write_enable = (k == mw[sel] - 1);
                seq.push_back(w);
            end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
                tk = (ins == I_BRANCH) || (ins == I_BZERO && ez) || (ins == I_BNZERO && !ez) ||
                     (ins == I_BNEG && en) || (ins == I_BNNEG && !en);
                w = '0; w.addr_sel = 1'b1; w.branch = tk; w.pc_enable = tk;
                seq.push_back(w);
            end
            I_HALT: for (int k = 0; k < 100; k++) begin
                w = '0; w.addr_sel = 1'b1; w.halted = 1'b1;
                seq.push_back(w);
            end
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (stop_at >= 0 && i >= stop_at) return;
            // Flags are valid only in the capture cycle; elsewhere present the inverse of the shadow.
            if (i == 0 && cap) set_in(sel, ins, pz[sel], pn[sel]);
            else               set_in(sel, ins, ~mz[sel], ~mn[sel]);
            step(sel, seq[i], $sformatf("%s c%0d", nm, i), 1'b1);
            if (i == 0 && cap) begin
                mz[sel] = pz[sel]; mn[sel] = pn[sel]; pend[sel] = 1'b0;
            end
        end
        if (ins == I_ADD || ins == I_SUB || ins == I_AND || ins == I_OR) begin
            pend[sel] = 1'b1; pz[sel] = rz; pn[sel] = rn;
        end
        if (ins != I_HALT) mret[sel] = mret[sel] + 16'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_w1 = 1'b1;
        rst_w3 = 1'b1;
        if_w1.unsigned_overflow = 1'b0; if_w1.signed_overflow = 1'b0;
        if_w3.unsigned_overflow = 1'b0; if_w3.signed_overflow = 1'b0;
        set_in(0, I_NOP, 1'b0, 1'b0);
        set_in(1, I_NOP, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // ---------------- MEM_WAIT = 1 ----------------
        do_reset(0, 2);
        check("w1 reset retired", 32'(retired_w1), 32'd0);
        check("w1 reset halted", 32'(halted_w1), 32'd0);
        issue(0, I_ADD, 1'b0, 1'b0, -1);
        check("w1 add retired", 32'(retired_w1), 32'd1);
        issue(0, I_SUB, 1'b1, 1'b0, -1);
        issue(0, I_MOVE, 1'b0, 1'b0, -1);
        issue(0, I_BZERO, 1'b0, 1'b0, -1);
        issue(0, I_BNZERO, 1'b0, 1'b0, -1);
        issue(0, I_ADD, 1'b0, 1'b1, -1);
        issue(0, I_BNEG, 1'b0, 1'b0, -1);
        issue(0, I_BNNEG, 1'b0, 1'b0, -1);
        issue(0, I_AND, 1'b0, 1'b0, -1);
        issue(0, I_BNEG, 1'b0, 1'b0, -1);
        issue(0, I_BNNEG, 1'b0, 1'b0, -1);
        issue(0, I_BZERO, 1'b0, 1'b0, -1);
        issue(0, I_BNZERO, 1'b0, 1'b0, -1);
        issue(0, I_OR, 1'b1, 1'b1, -1);
        issue(0, I_BRANCH, 1'b0, 1'b0, -1);
        issue(0, I_LOAD, 1'b0, 1'b0, -1);
        issue(0, I_STORE, 1'b0, 1'b0, -1);
        issue(0, I_NOP, 1'b0, 1'b0, -1);
        issue(0, decoded_instruction_type'(4'hE), 1'b0, 1'b0, -1);
        check("w1 retired count", 32'(retired_w1), 32'd19);

        // Walking 65k NOPs would take too long; jump the counter just below the wrap point.
        force u_dut_w1.retired = 16'hFFFD;
        #1;
        release u_dut_w1.retired;
        mret[0] = 16'hFFFD;
        issue(0, I_NOP, 1'b0, 1'b0, -1);
        issue(0, I_NOP, 1'b0, 1'b0, -1);
        check("w1 retired ffff", 32'(retired_w1), 32'h0000FFFF);
        issue(0, I_NOP, 1'b0, 1'b0, -1);
        check("w1 retired wrap", 32'(retired_w1), 32'd0);
        issue(0, I_HALT, 1'b0, 1'b0, -1);
        check("w1 halted", 32'(halted_w1), 32'd1);
        check("w1 halt retired", 32'(retired_w1), 32'd0);
        do_reset(0, 2);
        check("w1 post-halt halted", 32'(halted_w1), 32'd0);
        check("w1 post-halt addr_sel", 32'(if_w1.addr_sel), 32'd1);

        // ---------------- MEM_WAIT = 3 ----------------
        do_reset(1, 2);
        issue(1, I_LOAD, 1'b0, 1'b0, -1);
        issue(1, I_STORE, 1'b0, 1'b0, -1);
        check("w3 load cpi", 32'(ir_gap3), 32'd7);
        issue(1, I_ADD, 1'b1, 1'b0, -1);
        check("w3 store cpi", 32'(ir_gap3), 32'd7);
        issue(1, I_NOP, 1'b0, 1'b0, -1);
        check("w3 add cpi", 32'(ir_gap3), 32'd5);
        issue(1, I_MOVE, 1'b0, 1'b0, -1);
        check("w3 nop cpi", 32'(ir_gap3), 32'd4);
        issue(1, I_BZERO, 1'b0, 1'b0, -1);
        check("w3 retired", 32'(retired_w3), 32'd6);
        // Abort a LOAD after its first execute cycle.
        issue(1, I_LOAD, 1'b0, 1'b0, 5);
        check("w3 mid-load addr_sel", 32'(if_w3.addr_sel), 32'd0);
        do_reset(1, 2);
        check("w3 abort addr_sel", 32'(if_w3.addr_sel), 32'd1);
        check("w3 abort write_reg_enable", 32'(if_w3.write_reg_enable), 32'd0);
        check("w3 abort retired", 32'(retired_w3), 32'd0);
        check("w3 abort halted", 32'(halted_w3), 32'd0);
        issue(1, I_STORE, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ks_control_unit.md
Name: ks_control_unit

Overview:
Multi-cycle control FSM that sequences the K&S 16-bit datapath. It drives every datapath control input (branch, pc_enable, ir_enable, addr_sel, c_sel, operation, write_reg_enable, flags_reg_enable) and the RAM write strobe. It reads back decoded_instruction and the registered flags. It sits beside data_path inside the CPU top, between data_path and the 32x16 RAM.

Parameters:
MEM_WAIT, 1, RAM access cycles per read or write. Legal range 1..7. Address must be stable this many cycles before data_in is valid or before the write strobe.

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
decoded_instruction  input  decoded_instruction_type  opcode from data_path decoder (I_NOP..I_HALT)
zero_op  input  1  registered zero flag from data_path
neg_op  input  1  registered negative flag from data_path
unsigned_overflow  input  1  registered unsigned-overflow flag
signed_overflow  input  1  registered signed-overflow flag
branch  output  1  PC mux: 1 = mem_addr, 0 = PC+1
pc_enable  output  1  PC load
ir_enable  output  1  instruction register load
addr_sel  output  1  RAM address mux: 1 = PC, 0 = mem_addr
c_sel  output  1  register write mux: 1 = data_in, 0 = ALU
operation  output  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
write_reg_enable  output  1  register file write
flags_reg_enable  output  1  flag register load
ram_write_enable  output  1  RAM write strobe
halted  output  1  CPU stopped on HALT
retired  output  16  count of completed instructions

Behaviour:
- States: FETCH, DECODE, EXEC_ALU, EXEC_MOVE, EXEC_LOAD, EXEC_STORE, EXEC_BR, HALT.
- Outputs are combinational from the state and the wait counter. Default for every control output is 0, except addr_sel, which defaults to 1.
- Reset: state goes to FETCH, wait counter to 0, shadow flags to 0, retired to 0, halted to 0. All control outputs take their FETCH values. Reset in any state aborts the instruction in flight on the next edge.
- Wait counter (3 bits):
  - Counts 0..MEM_WAIT-1 in FETCH, EXEC_LOAD and EXEC_STORE.
  - Clears on every state change.
  - "Last" means cnt == MEM_WAIT-1.
- FETCH: addr_sel=1. On the last cycle, ir_enable=1 and the next state is DECODE.
- DECODE: pc_enable=1 and branch=0, so PC increments exactly once per instruction. Next state by decoded_instruction:
  - ADD, SUB, AND, OR go to EXEC_ALU.
  - MOVE goes to EXEC_MOVE.
  - LOAD goes to EXEC_LOAD.
  - STORE goes to EXEC_STORE.
  - BRANCH, BZERO, BNZERO, BNEG, BNNEG go to EXEC_BR.
  - HALT goes to HALT.
  - NOP and any unlisted value go to FETCH and count as retired.
- EXEC_ALU (1 cycle): write_reg_enable=1, flags_reg_enable=1, c_sel=0. operation is ADD 01, SUB 10, AND 11, OR 00. Next state is FETCH.
- EXEC_MOVE (1 cycle): operation=00 (OR of a with itself), write_reg_enable=1, flags_reg_enable=0. Next state is FETCH.
- EXEC_LOAD: addr_sel=0 and c_sel=1 for all cycles. write_reg_enable=1 on the last cycle only, then FETCH.
- EXEC_STORE: addr_sel=0 for all cycles. ram_write_enable=1 on the last cycle only, then FETCH.
- Shadow flags:
  - zero_op and neg_op are valid only in the cycle after flags_reg_enable, because data_path clears them otherwise.
  - The controller latches them into z_q/n_q on the first clock after EXEC_ALU and holds them until the next ALU instruction.
  - MOVE, LOAD and branches never modify z_q/n_q.
- EXEC_BR (1 cycle): taken = BRANCH, or BZERO & z_q, or BNZERO & !z_q, or BNEG & n_q, or BNNEG & !n_q. If taken, branch=1 and pc_enable=1. Next state is FETCH either way.
- retired increments on each transition into FETCH from EXEC_* or DECODE (NOP) and wraps at 16'hFFFF to 0. It does not increment for HALT.
- HALT: halted=1 and all strobes 0. Exit only via rst.
- Overflow inputs are unused for branching in this revision and are tapped only for debug.
- CPI with MEM_WAIT=W: ALU/MOVE/branch take W+2 cycles; LOAD/STORE take 2W+1; NOP takes W+1.

Test Plan:
- Reset: assert rst 2 cycles mid-EXEC_LOAD -> next cycle state FETCH, addr_sel=1, write_reg_enable=0, retired=0, halted=0.
- ADD sequence, W=1: feed I_ADD -> ir_enable at cycle 0, pc_enable at cycle 1, write_reg_enable=flags_reg_enable=1 with operation=01 at cycle 2, FETCH at cycle 3, retired=1.
- LOAD/STORE, W=3: I_LOAD -> addr_sel=0 and c_sel=1 for 3 cycles, write_reg_enable only on the 3rd; I_STORE -> ram_write_enable high exactly 1 cycle; 7 cycles per instruction.
- Branch conditions: SUB with zero_op=1 pulse after EXEC_ALU, then BZERO -> branch=pc_enable=1; then BNZERO -> pc_enable=0 in EXEC_BR; intervening MOVE does not clear z_q.
- BNEG/BNNEG: neg_op=1 captured -> BNEG taken, BNNEG not taken; neg_op=0 captured -> the reverse.
- HALT and counter wrap: preload retired=16'hFFFF via a NOP stream, one more NOP -> 0; I_HALT -> halted=1 and outputs frozen for 100 cycles; rst -> FETCH.
